// File: rtl/softmax_norm_pkg.sv
// Shared types and constants for the softmax row normaliser.
// Holds the per-bank state enum, Q2.13 constants and accumulator sizing helpers.
package softmax_norm_pkg;

    typedef enum logic {S_LOAD, S_EMIT} state_t;

    localparam int DATA_W   = 16;
    localparam int FRAC_BIT = 13;
    localparam int Q_ONE    = 1 << FRAC_BIT;

    function automatic int sat_max(input int d_w);
        return (1 << (d_w - 1)) - 1;
    endfunction

    localparam int SAT_MAX = sat_max(DATA_W);

    // Wide enough to sum ROW_LEN clamped (non-negative) scores without wrapping.
    function automatic int acc_w(input int d_w, input int row_len);
        return d_w - 1 + $clog2(row_len);
    endfunction

endpackage

// File: rtl/softmax_row_norm_if.sv
// Score input stream, weight output stream and external divider hookup.
// master = environment side, slave = normaliser side.
interface softmax_row_norm_if #(
    parameter int D_W = 16
);
    logic           score_valid;
    logic           score_ready;
    logic [D_W-1:0] score_data;
    logic           weight_valid;
    logic           weight_ready;
    logic [D_W-1:0] weight_data;
    logic           weight_last;
    logic [D_W-1:0] div_dividend;
    logic [D_W-1:0] div_divisor;
    logic [D_W-1:0] div_quotient;

    modport master (
        output score_valid, score_data, weight_ready, div_quotient,
        input  score_ready, weight_valid, weight_data, weight_last, div_dividend, div_divisor
    );

    modport slave (
        input  score_valid, score_data, weight_ready, div_quotient,
        output score_ready, weight_valid, weight_data, weight_last, div_dividend, div_divisor
    );
endinterface

// File: rtl/softmax_norm_buf.sv
// One row of scores: ROW_LEN x D_W register file, one write port, one async read port.
module softmax_norm_buf #(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 16,
    localparam int IDX_W  = $clog2(ROW_LEN)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [D_W-1:0]   wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [D_W-1:0]   rdata
);

    logic [D_W-1:0] mem [ROW_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_row_norm.sv
// Softmax row normaliser: buffers a row of exp scores, sums them, and registers exp_i/sum from
// an external divider. Optional macro SOFTMAX_NORM_PINGPONG_EN selects two banks for gapless rows.
module softmax_row_norm
    import softmax_norm_pkg::*;
#(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    softmax_row_norm_if.slave  bus
);

    localparam int ACC_W = acc_w(D_W, ROW_LEN);
    localparam int IDX_W = $clog2(ROW_LEN);
`ifdef SOFTMAX_NORM_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);
    localparam logic [ACC_W-1:0] SAT      = ACC_W'(sat_max(D_W));
    localparam logic             BANK_INC = 1'(NB - 1);

    state_t           bank_state_reg [NB];
    state_t           bank_state_next [NB];
    logic [ACC_W-1:0] acc_reg [NB];
    logic [ACC_W-1:0] acc_next [NB];
    logic [D_W-1:0]   divisor_reg [NB];
    logic [D_W-1:0]   divisor_next [NB];
    logic [D_W-1:0]   rd_data [NB];

    logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
    logic             load_bank_reg, load_bank_next;
    logic             emit_bank_reg, emit_bank_next;
    logic             weight_valid_reg, weight_valid_next;
    logic             weight_last_reg, weight_last_next;
    logic [D_W-1:0]   weight_data_reg, weight_data_next;

    logic             in_fire;
    logic             emitting;
    logic             out_load;
    logic [D_W-1:0]   clamped;
    logic [ACC_W-1:0] acc_sum;

    // Negative scores are stored and summed as zero so the dividend never exceeds the sum.
    assign clamped  = bus.score_data[D_W-1] ? '0 : bus.score_data;
    assign in_fire  = bus.score_valid && bus.score_ready;
    assign emitting = (bank_state_reg[emit_bank_reg] == S_EMIT);
    assign out_load = emitting && (!weight_valid_reg || bus.weight_ready);
    assign acc_sum  = acc_reg[load_bank_reg] + ACC_W'(clamped);

    assign bus.score_ready  = (bank_state_reg[load_bank_reg] == S_LOAD);
    assign bus.div_dividend = rd_data[emit_bank_reg];
    assign bus.div_divisor  = divisor_reg[emit_bank_reg];
    assign bus.weight_valid = weight_valid_reg;
    assign bus.weight_data  = weight_data_reg;
    assign bus.weight_last  = weight_last_reg;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bank
            softmax_norm_buf #(
                .D_W     (D_W),
                .ROW_LEN (ROW_LEN)
            ) u_buf (
                .clk   (clk),
                .we    (in_fire && (load_bank_reg == 1'(gi))),
                .waddr (wr_idx_reg),
                .wdata (clamped),
                .raddr (rd_idx_reg),
                .rdata (rd_data[gi])
            );
        end
    endgenerate

    // Each bank runs its own LOAD/EMIT cycle; load and emit pointers advance independently.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bank_state_next[b] = bank_state_reg[b];
            acc_next[b]        = acc_reg[b];
            divisor_next[b]    = divisor_reg[b];
        end
        wr_idx_next       = wr_idx_reg;
        rd_idx_next       = rd_idx_reg;
        load_bank_next    = load_bank_reg;
        emit_bank_next    = emit_bank_reg;
        weight_valid_next = weight_valid_reg;
        weight_last_next  = weight_last_reg;
        weight_data_next  = weight_data_reg;

        if (in_fire) begin
            acc_next[load_bank_reg] = acc_sum;
            wr_idx_next             = wr_idx_reg + 1'b1;
            if (wr_idx_reg == LAST_IDX) begin
                wr_idx_next                    = '0;
                bank_state_next[load_bank_reg] = S_EMIT;
                divisor_next[load_bank_reg]    = (acc_sum > SAT) ? D_W'(SAT) : D_W'(acc_sum);
                load_bank_next                 = load_bank_reg ^ BANK_INC;
            end
        end

        if (out_load) begin
            weight_valid_next = 1'b1;
            weight_data_next  = bus.div_quotient;
            weight_last_next  = (rd_idx_reg == LAST_IDX);
            rd_idx_next       = rd_idx_reg + 1'b1;
            if (rd_idx_reg == LAST_IDX) begin
                rd_idx_next                    = '0;
                acc_next[emit_bank_reg]        = '0;
                bank_state_next[emit_bank_reg] = S_LOAD;
                emit_bank_next                 = emit_bank_reg ^ BANK_INC;
            end
        end else if (bus.weight_ready) begin
            weight_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                bank_state_reg[b] <= S_LOAD;
                acc_reg[b]        <= '0;
                divisor_reg[b]    <= '0;
            end
            wr_idx_reg       <= '0;
            rd_idx_reg       <= '0;
            load_bank_reg    <= 1'b0;
            emit_bank_reg    <= 1'b0;
            weight_valid_reg <= 1'b0;
            weight_last_reg  <= 1'b0;
            weight_data_reg  <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                bank_state_reg[b] <= bank_state_next[b];
                acc_reg[b]        <= acc_next[b];
                divisor_reg[b]    <= divisor_next[b];
            end
            wr_idx_reg       <= wr_idx_next;
            rd_idx_reg       <= rd_idx_next;
            load_bank_reg    <= load_bank_next;
            emit_bank_reg    <= emit_bank_next;
            weight_valid_reg <= weight_valid_next;
            weight_last_reg  <= weight_last_next;
            weight_data_reg  <= weight_data_next;
        end
    end

endmodule

// File: tb/tb_softmax_row_norm.sv
// Scoreboard bench for softmax_row_norm with a behavioural Q2.13 divider.
// Covers SOFTMAX_NORM_PINGPONG_EN streaming when that macro is defined.
module tb_softmax_row_norm;
    import softmax_norm_pkg::*;

    typedef logic [15:0] row_t [16];
    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   out_count;
    int   ready_drops;
    logic watch_ready;
    exp_t exp_q [$];

    logic        held;
    logic [15:0] held_data;
    logic        held_last;

    softmax_row_norm_if #(.D_W(16)) bus ();

    softmax_row_norm #(.D_W(16), .ROW_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating fixed-point divider: quotient = dividend * 2^FRAC_BIT / divisor.
    always_comb begin
        if (bus.div_divisor == 16'h0000) begin
            bus.div_quotient = 16'h0000;
        end else begin
            bus.div_quotient = 16'((int'(bus.div_dividend) * Q_ONE) / int'(bus.div_divisor));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("[TB] ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                tests++;
                if (!(bus.weight_valid && bus.weight_data == held_data && bus.weight_last == held_last)) begin
                    fails++;
                    $display("[TB] FAIL hold: got v=%0b d=%04h l=%0b, expected v=1 d=%04h l=%0b",
                             bus.weight_valid, bus.weight_data, bus.weight_last, held_data, held_last);
                end
            end
            if (bus.weight_valid && bus.weight_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected: got d=%04h l=%0b, expected no output",
                             bus.weight_data, bus.weight_last);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.weight_data !== e.data || bus.weight_last !== e.last) begin
                        fails++;
                        $display("[TB] FAIL weight: got d=%04h l=%0b, expected d=%04h l=%0b",
                                 bus.weight_data, bus.weight_last, e.data, e.last);
                    end else begin
                        $display("[TB] out  d=%04h l=%0b", bus.weight_data, bus.weight_last);
                    end
                end
                out_count++;
            end
            if (watch_ready && bus.score_valid && !bus.score_ready) begin
                ready_drops++;
            end
            held      = bus.weight_valid && !bus.weight_ready;
            held_data = bus.weight_data;
            held_last = bus.weight_last;
        end
    end

    task automatic send_score(input logic [15:0] d);
        int n;
        bus.score_valid = 1'b1;
        bus.score_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.score_ready && n < 200);
        if (!bus.score_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL score_ready timeout: got 0, expected 1");
        end
        @(posedge clk);
        #1;
        bus.score_valid = 1'b0;
    endtask

    task automatic send_row(input row_t v, input row_t e);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({(i == 15), e[i]});
            send_score(v[i]);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int target);
        int n;
        n = 0;
        while (out_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("out_count_reached", 32'(out_count >= target), 32'd1);
    endtask

    task automatic fill(output row_t r, input logic [15:0] val);
        for (int i = 0; i < 16; i++) r[i] = val;
    endtask

    initial begin
        row_t v, e;
        int   base;
        tests       = 0;
        fails       = 0;
        out_count   = 0;
        ready_drops = 0;
        watch_ready = 1'b0;
        held        = 1'b0;
        rst              = 1'b1;
        bus.score_valid  = 1'b0;
        bus.score_data   = 16'h0000;
        bus.weight_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_weight_valid", 32'(bus.weight_valid), 32'd0);
        check("rst_weight_data", 32'(bus.weight_data), 32'd0);
        check("rst_weight_last", 32'(bus.weight_last), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_score_ready", 32'(bus.score_ready), 32'd1);

        // Single hot element: sum equals it, so it normalises to 1.0.
        fill(v, 16'h0000); fill(e, 16'h0000);
        v[3] = 16'h2000; e[3] = 16'h2000;
        send_row(v, e);
        check("divisor_single_hot", 32'(bus.div_divisor), 32'h2000);
`ifdef SOFTMAX_NORM_PINGPONG_EN
        check("ready_during_emit", 32'(bus.score_ready), 32'd1);
`else
        check("ready_during_emit", 32'(bus.score_ready), 32'd0);
`endif
        wait_drain("t1");

        fill(v, 16'h0200); fill(e, 16'h0200);
        send_row(v, e);
        check("divisor_uniform", 32'(bus.div_divisor), 32'h2000);
        wait_drain("t2");

        // Sum 0x20000 saturates the divisor.
        fill(v, 16'h2000); fill(e, 16'h0800);
        send_row(v, e);
        check("divisor_saturated", 32'(bus.div_divisor), 32'(SAT_MAX));
        wait_drain("t3");

        fill(v, 16'h0000); fill(e, 16'h0000);
        v[0] = 16'hF000; v[5] = 16'hF000; v[9] = 16'hF000;
        v[12] = 16'h1000; e[12] = 16'h2000;
        send_row(v, e);
        check("divisor_clamped", 32'(bus.div_divisor), 32'h1000);
        wait_drain("t4");

        fill(v, 16'h0000); fill(e, 16'h0000);
        send_row(v, e);
        wait_drain("t_zero");

        // Stall downstream for 5 cycles while element 7 is presented.
        for (int i = 0; i < 16; i++) begin
            v[i] = 16'(i + 1) << 6;
        end
        // Sum = 136*64 = 0x2200; quotient = floor((i+1)*64*8192/8704).
        e[0]  = 16'h003C; e[1]  = 16'h0078; e[2]  = 16'h00B4; e[3]  = 16'h00F0;
        e[4]  = 16'h012D; e[5]  = 16'h0169; e[6]  = 16'h01A5; e[7]  = 16'h01E1;
        e[8]  = 16'h021E; e[9]  = 16'h025A; e[10] = 16'h0296; e[11] = 16'h02D2;
        e[12] = 16'h030F; e[13] = 16'h034B; e[14] = 16'h0387; e[15] = 16'h03C3;
        base = out_count;
        send_row(v, e);
        wait_count(base + 7);
        @(posedge clk);
        #1;
        bus.weight_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.weight_ready = 1'b1;
        wait_drain("t5");
        check("t5_count", 32'(out_count - base), 32'd16);

        // Reset in the middle of emitting a row.
        fill(v, 16'h0200); fill(e, 16'h0200);
        base = out_count;
        send_row(v, e);
        wait_count(base + 4);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_weight_valid", 32'(bus.weight_valid), 32'd0);
        check("midrst_weight_data", 32'(bus.weight_data), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fill(v, 16'h0000); fill(e, 16'h0000);
        v[10] = 16'h0400; v[11] = 16'h0400;
        e[10] = 16'h1000; e[11] = 16'h1000;
        send_row(v, e);
        wait_drain("t6");

`ifdef SOFTMAX_NORM_PINGPONG_EN
        // Two back-to-back rows must stream without an input stall.
        base        = out_count;
        ready_drops = 0;
        watch_ready = 1'b1;
        fill(v, 16'h0200); fill(e, 16'h0200);
        send_row(v, e);
        fill(v, 16'h0000); fill(e, 16'h0000);
        v[1] = 16'h2000; e[1] = 16'h2000;
        send_row(v, e);
        watch_ready = 1'b0;
        wait_drain("pp");
        check("pp_ready_drops", 32'(ready_drops), 32'd0);
        check("pp_count", 32'(out_count - base), 32'd32);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
